reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised multi-read-port register file with a built-in register-busy scoreboard. It is the next generation of the CPU register bank and sits between decode/issue and writeback. Writes are synchronous to clk, with no separate write strobe edge. Read data is registered, with write-to-read bypass. A per-register busy bit lets issue logic stall on pending writebacks.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 is hardwired zero: never written, never busy

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rd_en  in  1  update all read outputs this cycle
rd_addr  in  NUM_RD*ADDR_W  read indices; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data, packed like rd_addr
rd_busy  out  NUM_RD  registered busy flag of the register read on each port
wr_en  in  1  writeback strobe, sampled at posedge clk
wr_addr  in  ADDR_W  writeback index
wr_data  in  DATA_W  writeback data
rsv_en  in  1  reserve (mark busy) register rsv_addr
rsv_addr  in  ADDR_W  reservation index
flush  in  1  clear all busy bits (pipeline flush); data untouched
busy_vec  out  2**ADDR_W  current busy bits, bit n = register n

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0, all busy bits = 0, rd_data = 0, rd_busy = 0. Applies immediately, including mid-operation, and holds while low. Release is synchronous in effect: the first capture happens at the first posedge after reset goes high.
- Write: at posedge, if wr_en then mem[wr_addr] <= wr_data. When ZERO_REG=1 and wr_addr=0, the write is ignored.
- Read: at posedge, if rd_en, for each port i with a = rd_addr[i]:
  - rd_data[i] <= wr_data if wr_en and wr_addr==a and not (ZERO_REG and a==0); otherwise rd_data[i] <= mem[a].
  - This is write-to-read bypass with 1-cycle latency.
- Read hold: when rd_en=0, rd_data and rd_busy hold their values.
- Reading register 0 with ZERO_REG=1 always returns 0.
- Busy bit n, next value, in priority order:
  - flush=1 -> 0 for all n. flush also overrides a rsv_en in the same cycle.
  - Otherwise, rsv_en and rsv_addr==n -> 1. A reservation and a write to the same register in the same cycle leave the bit set: the new reservation wins.
  - Otherwise, wr_en and wr_addr==n -> 0.
  - Otherwise, hold.
  - ZERO_REG=1 forces busy[0]=0.
- rd_busy[i] (when rd_en) <= busy[a] & ~(wr_en & wr_addr==a). It reflects the same-cycle writeback clear but not a same-cycle reservation.
- busy_vec is the registered busy state. It is not bypassed.
- A write to a non-busy register is legal: data updates, busy stays 0.
- Multiple read ports may address the same register; each gets the identical value.
- All indices are in range by construction (depth = 2**ADDR_W), so there is no out-of-range handling.

Decomposition:
- Package reg_file_pkg holds:
  - default DATA_W/ADDR_W/NUM_RD constants
  - a function for the packed-slice offset
  - the ZERO_REG encoding
- One sub-module, rf_scoreboard, holds the busy-bit array and its set/clear/flush priority logic and outputs busy_vec. The register array and read bypass stay in the top module.

Test Plan:
- Reset then read: reset low 2 cycles; release; rd_en=1, rd_addr={3,7} -> next cycle rd_data={0,0}, rd_busy=00, busy_vec=0.
- Write then read: wr_en, wr_addr=5, wr_data=0xDEADBEEF. Next cycle rd_en, rd_addr port0=5 -> rd_data port0=0xDEADBEEF one cycle later.
- Bypass: same cycle wr_en, wr_addr=9, wr_data=0x12345678 and rd_en, rd_addr={9,9} -> both ports 0x12345678 next cycle.
- Zero register: wr_en, wr_addr=0, wr_data=0xFFFFFFFF; rsv_en, rsv_addr=0 -> read 0 gives 0, busy_vec[0]=0.
- Scoreboard:
  - rsv_en addr 4 -> busy_vec[4]=1; a read of 4 gives rd_busy=1.
  - Then wr_en addr 4 with rd_en on 4 in the same cycle -> rd_busy=0, busy_vec[4]=0 next cycle.
  - Same-cycle rsv_en and wr_en on addr 6 -> busy_vec[6]=1.
- Flush/reset mid-operation:
  - Reserve regs 2,3,8, then flush with rsv_en addr 10 -> busy_vec=0.
  - Then assert reset asynchronously between clock edges -> rd_data=0 immediately and all register contents read back 0 after release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file with busy scoreboard.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  // Selects whether register 0 is a hardwired zero.
  typedef enum logic {
    ZERO_REG_OFF = 1'b0,
    ZERO_REG_ON  = 1'b1
  } zero_reg_e;

  // Bit offset of element idx inside a packed bus of width-wide elements.
  function automatic int unsigned slice_off(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Issue/writeback-side bundle of the register file: read ports, writeback, reservations.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     flush;
  logic [2**ADDR_W-1:0]     busy_vec;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: flush beats reservation, reservation beats writeback clear.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int        ADDR_W   = ADDR_W_DEF,
  parameter zero_reg_e ZERO_REG = ZERO_REG_ON
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic                 flush,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_d, busy_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    // Later assignments take priority: clear, then set, then flush.
    if (wr_en)  busy_d[wr_addr]  = 1'b0;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (flush)  busy_d           = '0;
    if (ZERO_REG == ZERO_REG_ON) busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with registered, write-bypassed reads and a busy scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int        DATA_W   = DATA_W_DEF,
  parameter int        ADDR_W   = ADDR_W_DEF,
  parameter int        NUM_RD   = NUM_RD_DEF,
  parameter zero_reg_e ZERO_REG = ZERO_REG_ON
) (
  input logic          clk,
  input logic          reset,
  reg_file_sb_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_d, mem_q;
  logic [NUM_RD*DATA_W-1:0]     rd_data_d, rd_data_q;
  logic [NUM_RD-1:0]            rd_busy_d, rd_busy_q;
  logic [ADDR_W-1:0]            rd_idx [NUM_RD];
  logic [DEPTH-1:0]             busy_vec;
  logic                         wr_fire;

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .rsv_en  (bus.rsv_en),
    .rsv_addr(bus.rsv_addr),
    .flush   (bus.flush),
    .busy_vec(busy_vec)
  );

  // A write to register 0 is dropped entirely when it is hardwired, including for bypass.
  assign wr_fire = bus.wr_en &&
                   !((ZERO_REG == ZERO_REG_ON) && (bus.wr_addr == '0));

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_idx[i] = bus.rd_addr[slice_off(i, ADDR_W) +: ADDR_W];
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_fire) mem_d[bus.wr_addr] = bus.wr_data;
  end

  // rd_busy sees the same-cycle writeback clear but not a same-cycle reservation.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    if (bus.rd_en) begin
      for (int i = 0; i < NUM_RD; i++) begin
        rd_data_d[slice_off(i, DATA_W) +: DATA_W] =
          (wr_fire && (bus.wr_addr == rd_idx[i])) ? bus.wr_data : mem_q[rd_idx[i]];
        rd_busy_d[i] = busy_vec[rd_idx[i]] &
                       ~(bus.wr_en && (bus.wr_addr == rd_idx[i]));
      end
    end
  end

  // NOTE: the array is built from flops, so it is reset like any other state; a RAM macro could not be.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q     <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_busy  = rd_busy_q;
  assign bus.busy_vec = busy_vec;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, async-reset sequence, random run vs reference model.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 2**AW;

  logic clk;
  logic reset;

  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) rf_bus ();

  reg_file_sb #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_RD  (NR),
    .ZERO_REG(ZERO_REG_ON)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (rf_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rd_en;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic          wr_en;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rsv_en;
    logic [AW-1:0] rsva;
    logic          flush;
    logic [DW-1:0] e_d0;
    logic [DW-1:0] e_d1;
    logic [1:0]    e_busy;   // {port1, port0}
    logic [DEPTH-1:0] e_bv;
  } vec_t;

  vec_t vecs [15];

  task automatic drive(input logic rd_en, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input logic wr_en, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rsv_en, input logic [AW-1:0] rsva, input logic flush);
    rf_bus.rd_en    = rd_en;
    rf_bus.rd_addr  = {ra1, ra0};
    rf_bus.wr_en    = wr_en;
    rf_bus.wr_addr  = wa;
    rf_bus.wr_data  = wd;
    rf_bus.rsv_en   = rsv_en;
    rf_bus.rsv_addr = rsva;
    rf_bus.flush    = flush;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // Reference model state: plain arrays updated from the behavioural rules.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];
  logic [DW-1:0] m_rd   [NR];
  bit            m_rb   [NR];

  initial begin
    vecs[0]  = '{1'b1, 5'd3,  5'd7, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 32'h0};
    vecs[2]  = '{1'b1, 5'd5,  5'd5, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0};
    vecs[3]  = '{1'b1, 5'd9,  5'd9, 1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0,  1'b0, 32'h12345678, 32'h12345678, 2'b00, 32'h0};
    vecs[4]  = '{1'b1, 5'd0,  5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 32'h0};
    vecs[5]  = '{1'b1, 5'd0,  5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        32'h12345678, 2'b00, 32'h0};
    vecs[6]  = '{1'b1, 5'd4,  5'd5, 1'b0, 5'd0, 32'h0,        1'b1, 5'd4,  1'b0, 32'h0,        32'hDEADBEEF, 2'b00, 32'h10};
    vecs[7]  = '{1'b1, 5'd4,  5'd4, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        2'b11, 32'h10};
    vecs[8]  = '{1'b1, 5'd4,  5'd5, 1'b1, 5'd4, 32'hAAAA5555, 1'b0, 5'd0,  1'b0, 32'hAAAA5555, 32'hDEADBEEF, 2'b00, 32'h0};
    vecs[9]  = '{1'b1, 5'd6,  5'd4, 1'b1, 5'd6, 32'h66,       1'b1, 5'd6,  1'b0, 32'h66,       32'hAAAA5555, 2'b00, 32'h40};
    vecs[10] = '{1'b0, 5'd0,  5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd2,  1'b0, 32'h66,       32'hAAAA5555, 2'b00, 32'h44};
    vecs[11] = '{1'b0, 5'd0,  5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3,  1'b0, 32'h66,       32'hAAAA5555, 2'b00, 32'h4C};
    vecs[12] = '{1'b1, 5'd2,  5'd6, 1'b0, 5'd0, 32'h0,        1'b1, 5'd8,  1'b0, 32'h0,        32'h66,       2'b11, 32'h14C};
    vecs[13] = '{1'b0, 5'd0,  5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 1'b1, 32'h0,        32'h66,       2'b11, 32'h0};
    vecs[14] = '{1'b1, 5'd10, 5'd3, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 32'h0};

    // Power-on reset held for two cycles.
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_data",  64'(rf_bus.rd_data),  64'h0);
    check("reset_rd_busy",  64'(rf_bus.rd_busy),  64'h0);
    check("reset_busy_vec", 64'(rf_bus.busy_vec), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table: one cycle per record, outputs checked just after the edge.
    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].rd_en, vecs[v].ra0, vecs[v].ra1, vecs[v].wr_en, vecs[v].wa, vecs[v].wd,
            vecs[v].rsv_en, vecs[v].rsva, vecs[v].flush);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_rd_data0", v), 64'(rf_bus.rd_data[DW-1:0]),    64'(vecs[v].e_d0));
      check($sformatf("vec%0d_rd_data1", v), 64'(rf_bus.rd_data[2*DW-1:DW]), 64'(vecs[v].e_d1));
      check($sformatf("vec%0d_rd_busy", v),  64'(rf_bus.rd_busy),            64'(vecs[v].e_busy));
      check($sformatf("vec%0d_busy_vec", v), 64'(rf_bus.busy_vec),           64'(vecs[v].e_bv));
    end

    // Async reset between clock edges while data and busy bits are live.
    drive(1'b1, 5'd1, 5'd1, 1'b1, 5'd1, 32'hCAFEF00D, 1'b1, 5'd12, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_rd_data", 64'(rf_bus.rd_data), {32'hCAFEF00D, 32'hCAFEF00D});
    check("pre_reset_busy_vec", 64'(rf_bus.busy_vec), 64'h1000);
    idle();
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_rd_data",  64'(rf_bus.rd_data),  64'h0);
    check("async_reset_busy_vec", 64'(rf_bus.busy_vec), 64'h0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    for (int k = 0; k < DEPTH / 2; k++) begin
      drive(1'b1, 5'(2 * k), 5'(2 * k + 1), 1'b0, '0, '0, 1'b0, '0, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("post_reset_reg%0d_%0d", 2 * k, 2 * k + 1), 64'(rf_bus.rd_data), 64'h0);
    end

    // Randomised run against the model, starting from the all-zero post-reset state.
    for (int n = 0; n < DEPTH; n++) begin
      m_mem[n]  = '0;
      m_busy[n] = 1'b0;
    end
    for (int p = 0; p < NR; p++) begin
      m_rd[p] = '0;
      m_rb[p] = 1'b0;
    end

    for (int cyc = 0; cyc < 500; cyc++) begin
      logic          r_en, w_en, s_en, fl;
      logic [AW-1:0] ra [NR];
      logic [AW-1:0] wa, sa;
      logic [DW-1:0] wd;
      logic [DEPTH-1:0] exp_bv;
      logic [NR*DW-1:0] exp_rd;
      logic [NR-1:0]    exp_rb;

      r_en = ($urandom_range(0, 4) != 0);
      w_en = $urandom_range(0, 1) == 1;
      s_en = ($urandom_range(0, 2) == 0);
      fl   = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < NR; p++)
        ra[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
      wa = AW'($urandom_range(0, 7));
      sa = AW'($urandom_range(0, 7));
      wd = $urandom;
      drive(r_en, ra[0], ra[1], w_en, wa, wd, s_en, sa, fl);

      // Reads observe the pre-edge state plus the same-cycle write.
      if (r_en) begin
        for (int p = 0; p < NR; p++) begin
          m_rd[p] = (w_en && wa == ra[p] && ra[p] != 0) ? wd : m_mem[ra[p]];
          m_rb[p] = m_busy[ra[p]] && !(w_en && wa == ra[p]);
        end
      end
      if (w_en && wa != 0) m_mem[wa] = wd;
      for (int n = 0; n < DEPTH; n++) begin
        if (fl)                     m_busy[n] = 1'b0;
        else if (s_en && sa == n)   m_busy[n] = 1'b1;
        else if (w_en && wa == n)   m_busy[n] = 1'b0;
        if (n == 0)                 m_busy[n] = 1'b0;
      end

      for (int n = 0; n < DEPTH; n++) exp_bv[n] = m_busy[n];
      for (int p = 0; p < NR; p++) begin
        exp_rd[p*DW +: DW] = m_rd[p];
        exp_rb[p]          = m_rb[p];
      end

      @(posedge clk);
      #1;
      check($sformatf("rand%0d_rd_data", cyc),  64'(rf_bus.rd_data),  64'(exp_rd));
      check($sformatf("rand%0d_rd_busy", cyc),  64'(rf_bus.rd_busy),  64'(exp_rb));
      check($sformatf("rand%0d_busy_vec", cyc), 64'(rf_bus.busy_vec), 64'(exp_bv));
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
